// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller and its forwarding unit.
// The forwarding priority rule lives here so every user agrees on it.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MD_WAIT  = 2'd2
    } hz_state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // The newer value (M) wins over the older one (W); x0 is never forwarded.
    function automatic logic [1:0] fwdSelect(
        input logic       regWriteM,
        input logic [4:0] rdM,
        input logic       regWriteW,
        input logic [4:0] rdW,
        input logic [4:0] rs
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (regWriteM && (rdM != REG_ZERO) && (rdM == rs)) begin
            sel = FWD_M;
        end else if (regWriteW && (rdW != REG_ZERO) && (rdW == rs)) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_unit.sv
// Combinational operand-forwarding selects for the two E-stage ALU operands.
module forward_unit
    import pipe_pkg::*;
(
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE
);

    always_comb begin
        ForwardAE = fwdSelect(RegWriteM, RdM, RegWriteW, RdW, Rs1E);
        ForwardBE = fwdSelect(RegWriteM, RdM, RegWriteW, RdW, Rs2E);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage RV32I pipeline, including
// fixed-latency data-memory waits and done-handshaked mul/div waits.
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic       ResultSrcE0,
    input  logic       PCSrcE,
    input  logic       MdStartE,
    input  logic       MdDoneE,
    input  logic       MemReqM,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushM,
    output logic       FlushW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE
);

    localparam bit MemWaitEn = (MEM_LAT > 1);
    localparam logic [CNT_W-1:0] MemWaitLoad = CNT_W'(MEM_LAT - 1);

    hz_state_t        state, stateNext;
    logic [CNT_W-1:0] counter, counterNext;
    logic             mdPend, mdPendNext;
    logic             mdEntry, mdEntryNext;
    logic             lwStall;
    logic [1:0]       fwdA, fwdB;

    forward_unit uForward (
        .Rs1E      (Rs1E),
        .Rs2E      (Rs2E),
        .RdM       (RdM),
        .RdW       (RdW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .ForwardAE (fwdA),
        .ForwardBE (fwdB)
    );

    assign ForwardAE = rst ? FWD_RF : fwdA;
    assign ForwardBE = rst ? FWD_RF : fwdB;

    assign lwStall = ResultSrcE0 && (RdE != REG_ZERO) && ((RdE == Rs1D) || (RdE == Rs2D));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            counter <= '0;
            mdPend  <= 1'b0;
            mdEntry <= 1'b0;
        end else begin
            state   <= stateNext;
            counter <= counterNext;
            mdPend  <= mdPendNext;
            mdEntry <= mdEntryNext;
        end
    end

    // mdEntry marks the first MD_WAIT cycle: a done level already present then
    // still costs one stall cycle instead of releasing immediately.
    always_comb begin
        stateNext   = state;
        counterNext = counter;
        mdPendNext  = mdPend;
        mdEntryNext = 1'b0;
        StallF      = 1'b0;
        StallD      = 1'b0;
        StallE      = 1'b0;
        StallM      = 1'b0;
        FlushD      = 1'b0;
        FlushE      = 1'b0;
        FlushM      = 1'b0;
        FlushW      = 1'b0;

        unique case (state)
            RUN: begin
                StallF = lwStall && !PCSrcE;
                StallD = lwStall;
                FlushD = PCSrcE;
                FlushE = lwStall || PCSrcE;
                if (MemReqM && MemWaitEn) begin
                    stateNext   = MEM_WAIT;
                    counterNext = MemWaitLoad;
                    mdPendNext  = MdStartE;
                end else if (MdStartE) begin
                    stateNext   = MD_WAIT;
                    mdEntryNext = 1'b1;
                end
            end

            MEM_WAIT: begin
                StallF      = 1'b1;
                StallD      = 1'b1;
                StallE      = 1'b1;
                StallM      = 1'b1;
                FlushW      = 1'b1;
                counterNext = counter - CNT_W'(1);
                if (counter <= CNT_W'(1)) begin
                    stateNext   = mdPend ? MD_WAIT : RUN;
                    mdEntryNext = mdPend;
                    mdPendNext  = 1'b0;
                end
            end

            MD_WAIT: begin
                if (MdDoneE && !mdEntry) begin
                    StallF    = lwStall && !PCSrcE;
                    StallD    = lwStall;
                    FlushD    = PCSrcE;
                    FlushE    = lwStall || PCSrcE;
                    stateNext = RUN;
                end else begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                    FlushM = 1'b1;
                    if (MdDoneE) begin
                        stateNext = RUN;
                    end
                end
            end

            default: begin
                stateNext = RUN;
            end
        endcase

        if (rst) begin
            StallF = 1'b0;
            StallD = 1'b0;
            StallE = 1'b0;
            StallM = 1'b0;
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushM = 1'b1;
            FlushW = 1'b1;
        end
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush/forward controller for the 5-stage RV32I pipeline (F, D, E, M, W).
- Drives the Stall/Flush inputs of the F/D, D/E, E/M and M/W pipeline registers.
- Generates the operand-forwarding selects for the E-stage ALU.
- Sequences multi-cycle waits for data memory (fixed latency) and the iterative mul/div unit (done handshake), in addition to load-use and taken-branch hazards.

Parameters:
- MEM_LAT, 1, data-memory access latency in cycles (1 = no wait; legal range 1..15).
- CNT_W, 4, width of the memory wait counter; must satisfy 2^CNT_W > MEM_LAT.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- Rs1D, Rs2D  in  5  source registers of the instruction in D
- Rs1E, Rs2E, RdE  in  5  sources and destination of the instruction in E
- ResultSrcE0  in  1  instruction in E is a load
- PCSrcE  in  1  taken branch/jump resolved in E
- MdStartE  in  1  single-cycle pulse: mul/div op entering E, unit started
- MdDoneE  in  1  mul/div result valid (level, held until consumed)
- MemReqM  in  1  load/store in M this cycle
- RdM, RdW  in  5  destinations in M and W
- RegWriteM, RegWriteW  in  1  write enables in M and W
- StallF, StallD, StallE, StallM  out  1  hold the PC / respective pipeline register
- FlushD, FlushE, FlushM, FlushW  out  1  zero the respective pipeline register (flush beats stall at the register)
- ForwardAE, ForwardBE  out  2  00 = RF, 10 = M ALU result, 01 = W result

Behaviour:
- Reset:
  - state = RUN, counter = 0, md_pend = 0.
  - While rst is high: all Stall outputs = 0, all Flush outputs = 1, Forward outputs = 00.
- States:
  - RUN: no multi-cycle operation outstanding.
  - MEM_WAIT: data-memory access in progress.
  - MD_WAIT: mul/div operation in progress.
- Forwarding (combinational, every state):
  - ForwardAE = 10 if RegWriteM & RdM != 0 & RdM == Rs1E.
  - Otherwise 01 if RegWriteW & RdW != 0 & RdW == Rs1E.
  - Otherwise 00. ForwardBE is the same using Rs2E.
  - M has priority over W.
- lwStall = ResultSrcE0 & RdE != 0 & (RdE == Rs1D | RdE == Rs2D).
- RUN outputs:
  - StallF = StallD = lwStall.
  - FlushD = PCSrcE.
  - FlushE = lwStall | PCSrcE.
  - StallE = StallM = FlushM = FlushW = 0.
  - lwStall and PCSrcE are mutually exclusive (a load is not a branch). If both are asserted, the flush terms still apply and StallF must be 0, so the branch target is fetched.
- RUN transitions, evaluated on the rising edge:
  - MemReqM & MEM_LAT > 1 -> MEM_WAIT, counter = MEM_LAT-1, md_pend = MdStartE.
  - Else MdStartE -> MD_WAIT.
  - Else stay in RUN.
- MEM_WAIT outputs: StallF/D/E/M = 1, FlushW = 1, all other flushes 0.
- MEM_WAIT counting: counter decrements each cycle. On the cycle counter == 1, outputs are still stalled and the next state is MD_WAIT if md_pend, else RUN. md_pend is cleared on exit.
- MD_WAIT outputs: StallF/D/E = 1, FlushM = 1 (bubble into M), StallM = 0, all other flushes 0.
- MD_WAIT exit: on MdDoneE, outputs that cycle equal the RUN equations and the next state is RUN.
- MdDoneE already high on MD_WAIT entry: stall exactly one cycle.
- PCSrcE during MEM_WAIT or MD_WAIT is ignored. The branch remains in E (stalled) and is acted on when RUN resumes.
- rst mid-wait: return to RUN, counter and md_pend cleared, same cycle as reset.
- No combinational path from clk-domain state to the Forward outputs. Stall/Flush outputs are a function of state plus current inputs (Mealy).

Decomposition:
- Shared package pipe_pkg: hz_state_t enum {RUN, MEM_WAIT, MD_WAIT}; FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10 constants; REG_ZERO = 5'd0.
- One sub-module: forward_unit (purely combinational Forward{A,B}E logic), instantiated once. FSM and hazard logic stay in the top.

Test Plan:
- Load-use: lw x5 in E (ResultSrcE0 = 1, RdE = 5), Rs1D = 5 -> one cycle of StallF = StallD = 1, FlushE = 1; next cycle all 0. Repeat with RdE = 0 -> no stall.
- Forward priority: RdM = RdW = 7, both RegWrite = 1, Rs1E = 7, Rs2E = 7 -> ForwardAE = ForwardBE = 10. With RegWriteM = 0 -> 01. With RdM = RdW = 0 -> 00.
- Taken branch: PCSrcE = 1 in RUN -> FlushD = FlushE = 1, StallF = 0 for one cycle.
- Memory wait, MEM_LAT = 3: MemReqM pulse -> StallF/D/E/M = 1 and FlushW = 1 for exactly 2 cycles, then RUN.
- Memory wait with simultaneous MdStartE, MEM_LAT = 3: 2 cycles in MEM_WAIT, then MD_WAIT. MdDoneE asserted 4 cycles later -> StallF/D/E and FlushM held through those cycles, released on the MdDoneE cycle.
- Reset mid-MD_WAIT: rst = 1 for 1 cycle -> all Flush outputs = 1, all Stall outputs = 0. After reset, state = RUN and stalls stay 0 with MdDoneE = 0.
